// File: rtl/usr_shift_engine.sv
// Universal shift register with a valid/ready command front end. Load and zero-step
// commands complete at acceptance; a multi-step command moves one bit position per clock.
module usr_shift_engine #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_mode,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             ser_in_lo,
   input  logic             ser_in_hi,
   output logic [WIDTH-1:0] dout,
   output logic             ser_out_lo,
   output logic             ser_out_hi,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHU  = 3'b001;
   localparam logic [2:0] M_SHD  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROU  = 3'b100;
   localparam logic [2:0] M_ROD  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;

   state_t           state, state_nx;
   logic [AMT_W-1:0] count, count_nx;
   logic [2:0]       mode_q, mode_nx;
   logic [WIDTH-1:0] dout_nx;
   logic             done_nx;
   logic             accept, is_step_mode, last_step;
   logic [WIDTH-1:0] step_val;

   assign accept       = cmd_valid && (state == IDLE);
   assign is_step_mode = (cmd_mode != M_HOLD) && (cmd_mode != M_LOAD) && (cmd_mode != 3'b111);
   assign last_step    = (count == AMT_W'(1));

   // State register
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept && is_step_mode && (cmd_amt != '0)) state_nx = RUN;
         RUN:  if (last_step) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      cmd_ready = (state == IDLE);
      busy      = (state == RUN);
   end

   // Single-bit step of the latched mode; serial fill inputs are sampled live
   always_comb begin
      step_val = dout;
      case (mode_q)
         M_SHU: step_val = {dout[WIDTH-2:0], ser_in_lo};
         M_SHD: step_val = {ser_in_hi, dout[WIDTH-1:1]};
         M_ROU: step_val = {dout[WIDTH-2:0], dout[WIDTH-1]};
         M_ROD: step_val = {dout[0], dout[WIDTH-1:1]};
         M_ASR: step_val = {dout[WIDTH-1], dout[WIDTH-1:1]};
         default: step_val = dout;
      endcase
   end

   always_comb begin
      dout_nx  = dout;
      count_nx = count;
      mode_nx  = mode_q;
      done_nx  = 1'b0;
      if (state == RUN) begin
         dout_nx  = step_val;
         count_nx = count - AMT_W'(1);
         done_nx  = last_step;
      end else if (accept) begin
         if (cmd_mode == M_LOAD) begin
            dout_nx = cmd_data;
            done_nx = 1'b1;
         end else if (is_step_mode && (cmd_amt != '0)) begin
            mode_nx  = cmd_mode;
            count_nx = cmd_amt;
         end else begin
            done_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         dout   <= '0;
         count  <= '0;
         mode_q <= '0;
         done   <= 1'b0;
      end else begin
         dout   <= dout_nx;
         count  <= count_nx;
         mode_q <= mode_nx;
         done   <= done_nx;
      end
   end

   assign ser_out_lo = dout[0];
   assign ser_out_hi = dout[WIDTH-1];

endmodule

// File: tb/tb_usr_shift_engine.sv
// Directed bench for usr_shift_engine (WIDTH=8, AMT_W=4) with hand-computed expectations.
module tb_usr_shift_engine;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_mode;
   logic [3:0] cmd_amt;
   logic [7:0] cmd_data;
   logic       ser_in_lo;
   logic       ser_in_hi;
   logic [7:0] dout;
   logic       ser_out_lo;
   logic       ser_out_hi;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   usr_shift_engine #(.WIDTH(8), .AMT_W(4)) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_amt    (cmd_amt),
      .cmd_data   (cmd_data),
      .ser_in_lo  (ser_in_lo),
      .ser_in_hi  (ser_in_hi),
      .dout       (dout),
      .ser_out_lo (ser_out_lo),
      .ser_out_hi (ser_out_hi),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command, then wait (bounded) for done; reports busy cycles seen
   task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                          output int busy_cyc, output logic got_done);
      cmd_mode  = m;
      cmd_amt   = a;
      cmd_data  = d;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      busy_cyc  = 0;
      got_done  = done;
      for (int i = 0; i < 40 && !got_done; i++) begin
         if (busy) busy_cyc++;
         tick();
         got_done = done;
      end
   endtask

   int   bc;
   logic gd;

   initial begin
      clear_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_amt = '0; cmd_data = '0;
      ser_in_lo = 1'b0; ser_in_hi = 1'b0;

      // 1. reset
      repeat (3) tick();
      clear_n = 1'b1;
      tick();
      chk("rst_dout", dout, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      run_cmd(3'b011, 4'd0, 8'h5A, bc, gd);
      chk("pre_async_dout", dout, 8'h5A);
      #2 clear_n = 1'b0;
      #1 chk("async_clr_dout", dout, 8'h00);
      chk("async_clr_done", done, 1'b0);
      tick();
      clear_n = 1'b1;
      tick();

      // 2. load
      run_cmd(3'b011, 4'd7, 8'hA5, bc, gd);
      chk("load_dout", dout, 8'hA5);
      chk("load_done", gd, 1'b1);
      chk("load_busy_cyc", bc, 0);
      tick();
      chk("load_done_pulse", done, 1'b0);

      // 3. shift up by 3 with ser_in_lo=1, checked step by step
      ser_in_lo = 1'b1;
      cmd_mode = 3'b001; cmd_amt = 4'd3; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("shu_e0_busy", busy, 1'b1);
      chk("shu_e0_ready", cmd_ready, 1'b0);
      chk("shu_e0_dout", dout, 8'hA5);
      tick();
      chk("shu_e1_dout", dout, 8'h4B);
      chk("shu_e1_hi", ser_out_hi, 1'b0);
      chk("shu_e1_done", done, 1'b0);
      tick();
      chk("shu_e2_dout", dout, 8'h97);
      chk("shu_e2_hi", ser_out_hi, 1'b1);
      chk("shu_e2_busy", busy, 1'b1);
      tick();
      chk("shu_e3_dout", dout, 8'h2F);
      chk("shu_e3_busy", busy, 1'b0);
      chk("shu_e3_done", done, 1'b1);
      chk("shu_e3_ready", cmd_ready, 1'b1);
      chk("shu_e3_lo", ser_out_lo, 1'b1);
      tick();
      chk("shu_done_pulse", done, 1'b0);
      ser_in_lo = 1'b0;

      // 4. rotate down, arithmetic, logical down, rotate by WIDTH
      run_cmd(3'b101, 4'd4, 8'h00, bc, gd);
      chk("rod4_dout", dout, 8'hF2);
      chk("rod4_busy_cyc", bc, 4);
      run_cmd(3'b011, 4'd0, 8'h92, bc, gd);
      run_cmd(3'b110, 4'd2, 8'h00, bc, gd);
      chk("asr2_dout", dout, 8'hE4);
      chk("asr2_busy_cyc", bc, 2);
      run_cmd(3'b010, 4'd8, 8'h00, bc, gd);
      chk("shd8_dout", dout, 8'h00);
      chk("shd8_busy_cyc", bc, 8);
      run_cmd(3'b011, 4'd0, 8'hA5, bc, gd);
      run_cmd(3'b100, 4'd8, 8'h00, bc, gd);
      chk("rou8_dout", dout, 8'hA5);
      chk("rou8_done", gd, 1'b1);
      ser_in_lo = 1'b1;
      run_cmd(3'b001, 4'd10, 8'h00, bc, gd);
      chk("shu10_dout", dout, 8'hFF);
      chk("shu10_busy_cyc", bc, 10);
      ser_in_lo = 1'b0;

      // 5. zero amount and reserved mode
      run_cmd(3'b011, 4'd0, 8'h3C, bc, gd);
      tick();
      run_cmd(3'b001, 4'd0, 8'h00, bc, gd);
      chk("amt0_done", done, 1'b1);
      chk("amt0_busy", busy, 1'b0);
      chk("amt0_dout", dout, 8'h3C);
      tick();
      run_cmd(3'b111, 4'd5, 8'hFF, bc, gd);
      chk("rsv_done", done, 1'b1);
      chk("rsv_busy", busy, 1'b0);
      chk("rsv_dout", dout, 8'h3C);

      // 6a. command held valid through RUN
      run_cmd(3'b011, 4'd0, 8'h81, bc, gd);
      cmd_mode = 3'b100; cmd_amt = 4'd2; cmd_valid = 1'b1;
      tick();
      cmd_mode = 3'b011; cmd_data = 8'h3C;
      tick();
      chk("hold_e1_dout", dout, 8'h03);
      chk("hold_e1_busy", busy, 1'b1);
      tick();
      chk("hold_e2_dout", dout, 8'h06);
      chk("hold_e2_done", done, 1'b1);
      tick();
      cmd_valid = 1'b0;
      chk("b2b_dout", dout, 8'h3C);
      chk("b2b_done", done, 1'b1);
      tick();
      chk("b2b_done_clr", done, 1'b0);

      // 6b. back-to-back into a multi-step command drops done at E0
      cmd_mode = 3'b001; cmd_amt = 4'd1; cmd_valid = 1'b1;
      tick();
      cmd_mode = 3'b011; cmd_data = 8'h00;
      chk("b2b_run_done", done, 1'b0);
      chk("b2b_run_busy", busy, 1'b1);
      cmd_valid = 1'b0;
      tick();
      chk("b2b_run_dout", dout, 8'h78);

      // 6c. reset mid-run
      run_cmd(3'b011, 4'd0, 8'hFF, bc, gd);
      cmd_mode = 3'b001; cmd_amt = 4'd5; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("abort_pre_dout", dout, 8'hFC);
      #2 clear_n = 1'b0;
      #1 chk("abort_dout", dout, 8'h00);
      chk("abort_busy", busy, 1'b0);
      tick();
      clear_n = 1'b1;
      gd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         gd = gd | done | busy;
      end
      chk("abort_no_done", gd, 1'b0);
      run_cmd(3'b011, 4'd0, 8'h11, bc, gd);
      ser_in_lo = 1'b1;
      run_cmd(3'b001, 4'd1, 8'h00, bc, gd);
      chk("after_abort_dout", dout, 8'h23);
      chk("after_abort_busy_cyc", bc, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
